// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the RAM arbiter slice.
package mem_arb_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  // Minimum bit width able to hold values 0..n-1 (never less than 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < n) r = b + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-base priority picker: first masked requester at or after i_base wins.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_base,
  input  logic [N-1:0]    i_mask,
  output logic [N-1:0]    o_gnt
);

  int   idx;
  logic found;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_base) + k) % N;
      if (!found && i_req[idx[ID_W-1:0]] && i_mask[idx[ID_W-1:0]]) begin
        o_gnt[idx[ID_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-master arbiter in front of one single-port synchronous RAM, with bounded
// bus locking and a read-return pipeline that routes data to the issuer.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RD_LATENCY  = 1,
  parameter int ARB_MODE    = ARB_RR,
  parameter int LOCK_MAX    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_be,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int ID_W  = clog2(NUM_MASTERS);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = clog2(LOCK_MAX + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [ID_W-1:0]        r_last_gnt;
  logic                   r_lock_act;
  logic [ID_W-1:0]        r_lock_id;
  logic [CNT_W-1:0]       r_lock_cnt;
  logic [NUM_MASTERS-1:0] r_excl;
  logic [RD_LATENCY-1:0]  r_pipe_vld;
  logic [ID_W-1:0]        r_pipe_id [RD_LATENCY];

  logic                   w_locked;
  logic [CNT_W-1:0]       w_cnt;
  logic [ID_W-1:0]        w_base;
  logic [NUM_MASTERS-1:0] w_mask;
  logic [NUM_MASTERS-1:0] w_pick;
  logic [NUM_MASTERS-1:0] w_gnt;
  logic [ID_W-1:0]        w_gnt_id;
  logic                   w_any;

  assign w_locked = r_lock_act && m_req[r_lock_id];
  assign w_cnt    = w_locked ? r_lock_cnt : '0;
  // A master just forced off the bus sits out one arbitration if anyone else wants it.
  assign w_mask   = (|(m_req & ~r_excl)) ? ~r_excl : '1;

  always_comb begin
    w_base = '0;
    if (ARB_MODE == ARB_RR) w_base = (r_last_gnt == LAST_ID) ? '0 : r_last_gnt + 1'b1;
  end

  rr_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_pick (
    .i_req  (m_req),
    .i_base (w_base),
    .i_mask (w_mask),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_gnt = '0;
    if (reset) begin
      if (w_locked) w_gnt[r_lock_id] = 1'b1;
      else          w_gnt = w_pick;
    end
  end

  always_comb begin
    w_gnt_id  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_gnt[i]) begin
        w_gnt_id  = ID_W'(i);
        mem_we    = m_we[i];
        mem_addr  = m_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = m_wdata[i*DATA_W +: DATA_W];
        mem_be    = m_be[i*BE_W +: BE_W];
      end
    end
  end

  assign w_any   = |w_gnt;
  assign m_gnt   = w_gnt;
  assign mem_en  = w_any;
  assign m_rdata = mem_rdata;

  always_comb begin
    m_rvalid = '0;
    if (r_pipe_vld[RD_LATENCY-1]) m_rvalid[r_pipe_id[RD_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_gnt <= LAST_ID;
      r_lock_act <= 1'b0;
      r_lock_id  <= '0;
      r_lock_cnt <= '0;
      r_excl     <= '0;
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_any && !mem_we;
      r_pipe_id[0]  <= w_gnt_id;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
      if (w_any) begin
        r_last_gnt <= w_gnt_id;
        r_excl     <= '0;
        r_lock_act <= 1'b0;
        r_lock_cnt <= '0;
        if (m_lock[w_gnt_id]) begin
          if (w_cnt < CNT_LAST) begin
            r_lock_act <= 1'b1;
            r_lock_id  <= w_gnt_id;
            r_lock_cnt <= w_cnt + 1'b1;
          end else begin
            r_excl <= w_gnt;
          end
        end
      end else begin
        r_lock_act <= 1'b0;
        r_lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: a round-robin/latency-1 arbiter and a fixed-priority/latency-3
// arbiter driven by the same master stimulus, each with its own RAM model.
module tb_mem_arbiter_rr;

  logic        clk;
  logic        reset;
  logic [3:0]  m_req, m_we, m_lock;
  logic [51:0] m_addr;
  logic [127:0] m_wdata;
  logic [15:0] m_be;

  logic [3:0]  a_gnt, a_rvalid, a_mem_be;
  logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_en, a_mem_we;
  logic [12:0] a_mem_addr;

  logic [3:0]  b_gnt, b_rvalid, b_mem_be;
  logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata, b_q0, b_q1;
  logic        b_mem_en, b_mem_we;
  logic [12:0] b_mem_addr;

  logic [31:0] ram_a [0:8191];

  int checks = 0;
  int errors = 0;

  mem_arbiter_rr #(.NUM_MASTERS(4), .ADDR_W(13), .DATA_W(32), .RD_LATENCY(1),
                   .ARB_MODE(1), .LOCK_MAX(4)) u_dut_a (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_gnt(a_gnt),
    .m_rvalid(a_rvalid), .m_rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .mem_rdata(a_mem_rdata)
  );

  mem_arbiter_rr #(.NUM_MASTERS(4), .ADDR_W(13), .DATA_W(32), .RD_LATENCY(3),
                   .ARB_MODE(0), .LOCK_MAX(8)) u_dut_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_gnt(b_gnt),
    .m_rvalid(b_rvalid), .m_rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM A: one-cycle read latency, byte-enable writes.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) ram_a[a_mem_addr][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      end else begin
        a_mem_rdata <= ram_a[a_mem_addr];
      end
    end
  end

  // RAM B: three-cycle read latency, returns the address as data.
  always @(posedge clk) begin
    if (b_mem_en && !b_mem_we) b_q0 <= {19'h0, b_mem_addr};
    b_q1        <= b_q0;
    b_mem_rdata <= b_q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b0;
    m_req   = 4'b0011;
    m_we    = '0;
    m_lock  = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;

    // Held in reset with requests pending.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_gnt_a", 32'(a_gnt), 32'h0);
      chk("rst_en_a", 32'(a_mem_en), 32'h0);
      chk("rst_rvalid_a", 32'(a_rvalid), 32'h0);
      chk("rst_gnt_b", 32'(b_gnt), 32'h0);
    end
    @(negedge clk); reset = 1'b1; #1;
    chk("first_gnt_a", 32'(a_gnt), 32'h1);
    chk("first_gnt_b", 32'(b_gnt), 32'h1);

    // Reset pulse, then round-robin fairness with all four masters reading.
    @(negedge clk); reset = 1'b0; m_req = '0;
    for (int i = 0; i < 4; i++) m_addr[i*13 +: 13] = 13'h100 + 13'(i);
    #1; chk("pulse_gnt_a", 32'(a_gnt), 32'h0);
    @(negedge clk); reset = 1'b1; m_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt_a", 32'(a_gnt), 32'h1 << (k % 4));
      chk("rr_addr_a", 32'(a_mem_addr), 32'h100 + 32'(k % 4));
      chk("rr_rvalid_a", 32'(a_rvalid), (k == 0) ? 32'h0 : (32'h1 << ((k - 1) % 4)));
      chk("fx_gnt_b", 32'(b_gnt), 32'h1);
      @(negedge clk);
    end
    m_req = '0; #1;
    chk("rr_rvalid_tail_a", 32'(a_rvalid), 32'h8);
    chk("idle_en_a", 32'(a_mem_en), 32'h0);

    // Masters 1 and 2 only: fixed always picks 1, round-robin alternates.
    @(negedge clk); m_req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fx_0110_gnt_b", 32'(b_gnt), 32'h2);
      chk("rr_0110_gnt_a", 32'(a_gnt), (c == 1) ? 32'h4 : 32'h2);
      @(negedge clk);
    end

    // Full write, partial write, then read back the merged word.
    m_req = 4'b0001; m_we = 4'b0001;
    m_addr[0 +: 13] = 13'h010; m_wdata[0 +: 32] = 32'h1234_5678; m_be[0 +: 4] = 4'b1111;
    #1;
    chk("wr0_gnt_a", 32'(a_gnt), 32'h1);
    chk("wr0_we_a", 32'(a_mem_we), 32'h1);
    @(negedge clk);
    m_req = 4'b0010; m_we = 4'b0010;
    m_addr[13 +: 13] = 13'h010; m_wdata[32 +: 32] = 32'hDEAD_BEEF; m_be[4 +: 4] = 4'b0011;
    #1;
    chk("wr1_gnt_a", 32'(a_gnt), 32'h2);
    chk("wr1_addr_a", 32'(a_mem_addr), 32'h010);
    chk("wr1_wdata_a", a_mem_wdata, 32'hDEAD_BEEF);
    chk("wr1_be_a", 32'(a_mem_be), 32'h3);
    chk("wr1_wdata_b", b_mem_wdata, 32'hDEAD_BEEF);
    chk("wr1_be_b", 32'(b_mem_be), 32'h3);
    @(negedge clk);
    m_req = 4'b0001; m_we = '0; m_be = '0;
    #1;
    chk("rd_gnt_a", 32'(a_gnt), 32'h1);
    chk("rd_we_a", 32'(a_mem_we), 32'h0);
    chk("wr_no_rvalid_a", 32'(a_rvalid), 32'h0);
    @(negedge clk); m_req = '0; #1;
    chk("raw_rvalid_a", 32'(a_rvalid), 32'h1);
    chk("raw_rdata_a", a_rdata, 32'h1234_BEEF);

    // Lock: master 0 locks, master 1 competes; limit of 4 on the RR arbiter.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; m_req = 4'b0011; m_lock = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("lock_gnt_a", 32'(a_gnt), (c == 4) ? 32'h2 : 32'h1);
      chk("lock_gnt_b", 32'(b_gnt), 32'h1);
      @(negedge clk);
    end
    m_req = '0; m_lock = '0;

    // Reset right after a read grant on the latency-3 arbiter drops that read.
    repeat (4) @(negedge clk);
    m_req = 4'b0100; #1;
    chk("mid_gnt_b", 32'(b_gnt), 32'h4);
    @(negedge clk); reset = 1'b0; m_req = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("drop_rvalid_b", 32'(b_rvalid), 32'h0);
      @(negedge clk);
      if (c == 0) reset = 1'b1;
    end

    // A fresh read afterwards returns exactly three cycles later.
    m_req = 4'b1000; m_addr[39 +: 13] = 13'h0AB; #1;
    chk("post_gnt_b", 32'(b_gnt), 32'h8);
    @(negedge clk); m_req = '0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("post_rvalid_b", 32'(b_rvalid), (c == 3) ? 32'h8 : 32'h0);
      if (c == 3) chk("post_rdata_b", b_rdata, 32'h0AB);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
